port_tx_responder: RTL

- Memory-mapped output-port transmitter. It is the write/transmit counterpart of the device-port receive path in the interface block.
- Sits on the shared addr_bus and a data_bus segment as a bus responder. The controller writes words to TX_ADDR; they are buffered in a FIFO.
- Each word is sent to an external device using a four-phase valid/ack handshake.
- Status is readable at STAT_ADDR.

---
 rtl/port_tx_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/port_tx_responder.sv
// Memory-mapped output-port transmitter: bus writes to TX_ADDR queue words in a FIFO,
// which are sent over a four-phase valid/ack handshake. Optional macro: PORT_TX_PARITY_EN.
module port_tx_responder #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] TX_ADDR    = 'hF0,
  parameter logic [DATA_WIDTH-1:0] STAT_ADDR  = 'hF1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] addr_bus,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic [DATA_WIDTH-1:0] dev_data,
  output logic                  dev_valid,
  input  logic                  dev_ack,
`ifdef PORT_TX_PARITY_EN
  output logic                  dev_parity,
`endif
  output logic                  tx_empty,
  output logic                  tx_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  ovf;
  logic                  tx_sel, push, drop, pop, stat_rd;
  logic [DATA_WIDTH-1:0] status;

  // Admission uses the registered full flag, so a same-cycle pop never frees a slot early.
  assign tx_sel  = wr_en && (addr_bus == TX_ADDR);
  assign push    = tx_sel && !tx_full;
  assign drop    = tx_sel && tx_full;
  assign pop     = (state == IDLE) && (count != '0) && !dev_ack;
  assign stat_rd = rd_en && (addr_bus == STAT_ADDR);

  // NOTE: every variable driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    status     = '0;
    status[0]  = tx_empty;
    status[1]  = tx_full;
    status[2]  = ovf;
    status[AW+3:3] = count;
`ifdef PORT_TX_PARITY_EN
    status[AW+4] = 1'b1;
`endif
  end

  // NOTE: the storage array has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_bus_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      tx_empty     <= 1'b1;
      tx_full      <= 1'b0;
      dev_valid    <= 1'b0;
      dev_data     <= '0;
      data_bus_out <= '0;
`ifdef PORT_TX_PARITY_EN
      dev_parity   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count    <= count_next;
      tx_full  <= (count_next == CW'(FIFO_DEPTH));
      tx_empty <= (count_next == '0);

      // Status captures the old ovf; an overflow in the same cycle wins over the clear.
      data_bus_out <= stat_rd ? status : '0;
      if (drop)         ovf <= 1'b1;
      else if (stat_rd) ovf <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            dev_data  <= mem[rd_ptr];
`ifdef PORT_TX_PARITY_EN
            dev_parity <= ^mem[rd_ptr];
`endif
            dev_valid <= 1'b1;
            rd_ptr    <= rd_ptr + AW'(1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (dev_ack) begin
            dev_valid <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!dev_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
